pll_lock_reset_sequencer: RTL and testbench

Free-running reset and lock supervisor for the 40 MHz system PLL. Runs on the 50 MHz reference clock that also feeds the PLL. Drives the PLL reset input, debounces the PLL locked output, then releases the 40 MHz-domain resets in ordered stages. On lock loss it reasserts the resets, re-resets the PLL and counts the fault.

---
 rtl/pll_lock_reset_sequencer_if.sv | 25 ++
 rtl/pll_lock_reset_sequencer.sv | 152 +++++++++++++++
 tb/tb_pll_lock_reset_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_reset_sequencer_if.sv
// Status and control bundle of the PLL lock / staged reset sequencer.
// The master side is the sequencer itself; the slave side is the system consuming its resets.
interface pll_lock_reset_sequencer_if #(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W      = 8
);
  logic                  locked_in;
  logic                  clear_counts;
  logic                  pll_rst;
  logic [NUM_STAGES-1:0] rst_out;
  logic                  ready;
  logic [2:0]            state;
  logic [CNT_W-1:0]      lock_loss_count;
  logic [CNT_W-1:0]      timeout_count;

  modport master (
    input  locked_in, clear_counts,
    output pll_rst, rst_out, ready, state, lock_loss_count, timeout_count
  );

  modport slave (
    output locked_in, clear_counts,
    input  pll_rst, rst_out, ready, state, lock_loss_count, timeout_count
  );
endinterface

// File: rtl/pll_lock_reset_sequencer.sv
// Supervises the system PLL: pulses its reset, debounces lock, releases the
// downstream resets in ordered stages and re-arms everything on lock loss.
module pll_lock_reset_sequencer #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int NUM_STAGES     = 3,
  parameter int STAGE_GAP      = 8,
  parameter int CNT_W          = 8
) (
  input logic                          clk,
  input logic                          rst,
  pll_lock_reset_sequencer_if.master   bus
);

  typedef enum logic [2:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  // The shared cycle counter must cover the longest dwell of any state.
  localparam int REL_END = NUM_STAGES * STAGE_GAP + 1;
  localparam int M1      = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int M2      = (M1 > STABLE_CYCLES) ? M1 : STABLE_CYCLES;
  localparam int CMAX    = (M2 > REL_END) ? M2 : REL_END;
  localparam int CW      = $clog2(CMAX + 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  state_t                state_r, next_state_s;
  logic [CW-1:0]         cnt_r, cnt_s;
  logic                  sync1_r, lk_r;
  logic                  pll_rst_r, pll_rst_s;
  logic [NUM_STAGES-1:0] rst_out_r, rst_out_s;
  logic                  ready_r, ready_s;
  logic [CNT_W-1:0]      ll_cnt_r, ll_cnt_s;
  logic [CNT_W-1:0]      to_cnt_r, to_cnt_s;
  logic                  inc_ll_s, inc_to_s;

  // Two-flop synchronizer for the asynchronous PLL lock indication.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 1'b0;
      lk_r    <= 1'b0;
    end else begin
      sync1_r <= bus.locked_in;
      lk_r    <= sync1_r;
    end
  end

  // Next-state, dwell counter, event counters and next registered outputs.
  always_comb begin
    next_state_s = PLL_RESET;
    inc_ll_s     = 1'b0;
    inc_to_s     = 1'b0;
    case (state_r)
      PLL_RESET: begin
        if (cnt_r == CW'(PLL_RST_CYCLES - 1)) next_state_s = WAIT_LOCK;
        else                                  next_state_s = PLL_RESET;
      end
      WAIT_LOCK: begin
        if (lk_r) begin
          next_state_s = STABLE;
        end else if (cnt_r == CW'(LOCK_TIMEOUT - 1)) begin
          next_state_s = PLL_RESET;
          inc_to_s     = 1'b1;
        end else begin
          next_state_s = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!lk_r)                                 next_state_s = WAIT_LOCK;
        else if (cnt_r == CW'(STABLE_CYCLES - 1))  next_state_s = RELEASE;
        else                                       next_state_s = STABLE;
      end
      RELEASE: begin
        if (!lk_r) begin
          next_state_s = PLL_RESET;
          inc_ll_s     = 1'b1;
        end else if (cnt_r == CW'(NUM_STAGES * STAGE_GAP)) begin
          next_state_s = RUN;
        end else begin
          next_state_s = RELEASE;
        end
      end
      RUN: begin
        if (!lk_r) begin
          next_state_s = PLL_RESET;
          inc_ll_s     = 1'b1;
        end else begin
          next_state_s = RUN;
        end
      end
      default: next_state_s = PLL_RESET;
    endcase

    // The counter restarts on every state change and parks once running.
    if (next_state_s != state_r) cnt_s = '0;
    else if (state_r == RUN)     cnt_s = cnt_r;
    else                         cnt_s = cnt_r + CW'(1);

    if (bus.clear_counts)  ll_cnt_s = '0;
    else if (inc_ll_s)     ll_cnt_s = sat_inc(ll_cnt_r);
    else                   ll_cnt_s = ll_cnt_r;

    if (bus.clear_counts)  to_cnt_s = '0;
    else if (inc_to_s)     to_cnt_s = sat_inc(to_cnt_r);
    else                   to_cnt_s = to_cnt_r;

    pll_rst_s = (next_state_s == PLL_RESET);
    ready_s   = (next_state_s == RUN);
    rst_out_s = '1;
    for (int k = 0; k < NUM_STAGES; k++) begin
      rst_out_s[k] = !((next_state_s == RUN) ||
                       ((next_state_s == RELEASE) && (cnt_s >= CW'((k + 1) * STAGE_GAP))));
    end
  end

  // State, counters and glitch-free registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= PLL_RESET;
      cnt_r     <= '0;
      pll_rst_r <= 1'b1;
      rst_out_r <= '1;
      ready_r   <= 1'b0;
      ll_cnt_r  <= '0;
      to_cnt_r  <= '0;
    end else begin
      state_r   <= next_state_s;
      cnt_r     <= cnt_s;
      pll_rst_r <= pll_rst_s;
      rst_out_r <= rst_out_s;
      ready_r   <= ready_s;
      ll_cnt_r  <= ll_cnt_s;
      to_cnt_r  <= to_cnt_s;
    end
  end

  assign bus.pll_rst         = pll_rst_r;
  assign bus.rst_out         = rst_out_r;
  assign bus.ready           = ready_r;
  assign bus.state           = state_r;
  assign bus.lock_loss_count = ll_cnt_r;
  assign bus.timeout_count   = to_cnt_r;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// Directed plus randomized bench for the PLL lock / staged reset sequencer,
// checked cycle by cycle against a phase/elapsed-time reference model.
module tb_pll_lock_reset_sequencer;
  localparam int PRC  = 16;
  localparam int TO   = 100;
  localparam int SC   = 1024;
  localparam int NS   = 3;
  localparam int GAP  = 8;
  localparam int CNTW = 8;
  localparam int SAT  = (1 << CNTW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  pll_lock_reset_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CNTW)) bus ();

  pll_lock_reset_sequencer #(
    .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT(TO), .STABLE_CYCLES(SC),
    .NUM_STAGES(NS), .STAGE_GAP(GAP), .CNT_W(CNTW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase number, edges elapsed since entering it, event tallies,
  // and the lock samples still travelling through the two synchronizer stages.
  int p, age, ll_m, to_m;
  bit q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    p = 0; age = 0; ll_m = 0; to_m = 0;
    q.delete();
    q.push_back(1'b0);
    q.push_back(1'b0);
  endtask

  task automatic model_edge();
    bit lk;
    int np;
    bit inc_ll, inc_to;
    lk = q.pop_front();
    q.push_back(bus.locked_in);
    np = p; inc_ll = 0; inc_to = 0;
    case (p)
      0: if (age == PRC - 1) np = 1;
      1: if (lk) np = 2; else if (age == TO - 1) begin np = 0; inc_to = 1; end
      2: if (!lk) np = 1; else if (age == SC - 1) np = 3;
      3: if (!lk) begin np = 0; inc_ll = 1; end else if (age == NS * GAP) np = 4;
      default: if (!lk) begin np = 0; inc_ll = 1; end
    endcase
    age = (np == p) ? age + 1 : 0;
    p = np;
    if (bus.clear_counts) begin ll_m = 0; to_m = 0; end
    else begin
      if (inc_ll && ll_m < SAT) ll_m++;
      if (inc_to && to_m < SAT) to_m++;
    end
  endtask

  function automatic logic [31:0] exp_rst_out();
    logic [31:0] v;
    v = 32'd0;
    for (int k = 0; k < NS; k++)
      v[k] = !(p == 4 || (p == 3 && age >= (k + 1) * GAP));
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("state",      32'(bus.state),           32'(p));
    check("pll_rst",    32'(bus.pll_rst),         32'(p == 0));
    check("rst_out",    32'(bus.rst_out),         exp_rst_out());
    check("ready",      32'(bus.ready),           32'(p == 4));
    check("lock_loss",  32'(bus.lock_loss_count), 32'(ll_m));
    check("timeouts",   32'(bus.timeout_count),   32'(to_m));
  endtask

  task automatic run_until(input int target, input int bound);
    int n;
    n = 0;
    while (p != target && n < bound) begin
      step();
      n++;
    end
    check("reach_state", 32'(bus.state), 32'(target));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_async_out",   32'(bus.rst_out), 32'(3'b111));
    check("rst_async_state", 32'(bus.state),   32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.locked_in    = 1'b1;
    bus.clear_counts = 1'b0;
    rst              = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_state",   32'(bus.state),           32'd0);
    check("reset_pll_rst", 32'(bus.pll_rst),         32'd1);
    check("reset_rst_out", 32'(bus.rst_out),         32'(3'b111));
    check("reset_ready",   32'(bus.ready),           32'd0);
    check("reset_counts",  32'(bus.lock_loss_count) + 32'(bus.timeout_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Clean power-up with lock tied high.
    repeat (PRC - 1) step();
    check("pll_rst_hold_15", 32'(bus.pll_rst), 32'd1);
    step();
    check("pll_rst_fall_16", 32'(bus.pll_rst), 32'd0);
    run_until(3, 2000);
    repeat (GAP - 1) step();
    check("stage0_before", 32'(bus.rst_out), 32'(3'b111));
    step();
    check("stage0_at_8",   32'(bus.rst_out), 32'(3'b110));
    repeat (GAP) step();
    check("stage1_at_16",  32'(bus.rst_out), 32'(3'b100));
    repeat (GAP) step();
    check("stage2_at_24",  32'(bus.rst_out), 32'(3'b000));
    check("ready_not_yet", 32'(bus.ready),   32'd0);
    step();
    check("ready_at_25",   32'(bus.ready),   32'd1);
    check("counts_zero",   32'(bus.lock_loss_count) + 32'(bus.timeout_count), 32'd0);

    // Lock glitch during STABLE: fall back and demand a full fresh window.
    do_reset();
    run_until(2, 200);
    repeat (500) step();
    bus.locked_in = 1'b0;
    step();
    bus.locked_in = 1'b1;
    run_until(1, 10);
    run_until(2, 10);
    repeat (SC - 1) step();
    check("fresh_window_hold", 32'(bus.state), 32'd2);
    step();
    check("fresh_window_done", 32'(bus.state), 32'd3);
    check("stable_glitch_no_count", 32'(bus.lock_loss_count), 32'd0);
    run_until(4, 100);

    // Single-cycle lock drop while running.
    bus.locked_in = 1'b0;
    step();
    bus.locked_in = 1'b1;
    step();
    step();
    check("loss_rst_out", 32'(bus.rst_out),         32'(3'b111));
    check("loss_ready",   32'(bus.ready),           32'd0);
    check("loss_pll_rst", 32'(bus.pll_rst),         32'd1);
    check("loss_count",   32'(bus.lock_loss_count), 32'd1);
    run_until(4, 3000);

    // Clear coinciding with a lock-loss increment.
    bus.locked_in = 1'b0;
    step();
    bus.locked_in = 1'b1;
    step();
    bus.clear_counts = 1'b1;
    step();
    bus.clear_counts = 1'b0;
    check("clear_wins", 32'(bus.lock_loss_count), 32'd0);
    check("clear_state", 32'(bus.state),          32'd0);

    // Asynchronous reset after the first stage has been released.
    run_until(3, 3000);
    repeat (GAP + 2) step();
    check("partial_release", 32'(bus.rst_out), 32'(3'b110));
    rst = 1'b1;
    #2;
    check("async_rst_out",   32'(bus.rst_out), 32'(3'b111));
    check("async_state",     32'(bus.state),   32'd0);
    check("async_pll_rst",   32'(bus.pll_rst), 32'd1);
    check("async_ready",     32'(bus.ready),   32'd0);
    model_reset();
    @(negedge clk);

    // No lock at all: periodic PLL retries and a saturating timeout count.
    bus.locked_in = 1'b0;
    rst = 1'b0;
    repeat (PRC) step();
    check("retry_pll_low", 32'(bus.pll_rst), 32'd0);
    repeat (TO - 1) step();
    check("retry_not_yet", 32'(bus.timeout_count), 32'd0);
    step();
    check("retry_at_116",  32'(bus.pll_rst),       32'd1);
    check("retry_count_1", 32'(bus.timeout_count), 32'd1);
    repeat ((PRC + TO) * 256) step();
    check("timeout_sat",   32'(bus.timeout_count), 32'(SAT));

    // Randomized lock behaviour with sporadic counter clears.
    do_reset();
    for (int seg = 0; seg < 25; seg++) begin
      int len;
      bus.locked_in = 1'($urandom_range(0, 1));
      len = bus.locked_in ? $urandom_range(1, 1200) : $urandom_range(1, 150);
      for (int c = 0; c < len; c++) begin
        bus.clear_counts = ($urandom_range(0, 199) == 0);
        step();
      end
      bus.clear_counts = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
